// File: rtl/i2c_slave_fsm.sv
// Simplified I2C-style slave clocked directly by SCL: address match with ACK,
// single-byte write into a data register and single-byte readback of it.
module i2c_slave_fsm #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010100,
    parameter logic [7:0] RESET_DATA = 8'h00
) (
    input  logic i2c_scl,
    input  logic reset_n,
    input  logic i2c_sda,
    output logic valid_address,
    output logic sda_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        RW        = 3'd2,
        ADDR_ACK  = 3'd3,
        WDATA     = 3'd4,
        WDATA_ACK = 3'd5,
        RDATA     = 3'd6,
        RDATA_ACK = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  data_q, data_d;
    logic        rw_q, rw_d;
    logic        valid_q, valid_d;
    logic        sda_q, sda_d;

    always_ff @(posedge i2c_scl or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            addr_q    <= 7'd0;
            rx_q      <= 8'd0;
            data_q    <= RESET_DATA;
            rw_q      <= 1'b0;
            valid_q   <= 1'b0;
            sda_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            rw_q      <= rw_d;
            valid_q   <= valid_d;
            sda_q     <= sda_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        data_d    = data_q;
        rw_d      = rw_q;
        valid_d   = valid_q;
        sda_d     = sda_q;

        unique case (state_q)
            IDLE: begin
                // A low SDA sampled while idle stands in for a start condition.
                if (!i2c_sda) begin
                    state_d   = ADDR;
                    bit_cnt_d = 3'd6;
                end
            end
            ADDR: begin
                addr_d[bit_cnt_q] = i2c_sda;
                if (bit_cnt_q == 3'd0) begin
                    state_d = RW;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            RW: begin
                rw_d = i2c_sda;
                if (addr_q == SLAVE_ADDR) begin
                    valid_d = 1'b1;
                    sda_d   = 1'b0;
                    state_d = ADDR_ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR_ACK: begin
                bit_cnt_d = 3'd7;
                if (rw_q) begin
                    sda_d   = data_q[7];
                    state_d = RDATA;
                end else begin
                    sda_d   = 1'b1;
                    state_d = WDATA;
                end
            end
            WDATA: begin
                rx_d[bit_cnt_q] = i2c_sda;
                if (bit_cnt_q == 3'd0) begin
                    data_d  = rx_d;
                    sda_d   = 1'b0;
                    state_d = WDATA_ACK;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            WDATA_ACK: begin
                sda_d   = 1'b1;
                valid_d = 1'b0;
                state_d = IDLE;
            end
            RDATA: begin
                if (bit_cnt_q == 3'd0) begin
                    sda_d   = 1'b1;
                    state_d = RDATA_ACK;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    sda_d     = data_q[bit_cnt_d];
                end
            end
            RDATA_ACK: begin
                // Master ACK/NACK is sampled but has no effect on a single-byte read.
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
                valid_d   = 1'b0;
                sda_d     = 1'b1;
            end
        endcase
    end

    assign valid_address = valid_q;
    assign sda_out       = sda_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm: reset, address match/mismatch, write, read, mid-frame reset.
module tb_i2c_slave_fsm;

    logic i2c_scl = 1'b0;
    logic reset_n;
    logic i2c_sda;
    logic valid_address;
    logic sda_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR_ACK  = 3'd3;
    localparam logic [2:0] S_WDATA     = 3'd4;
    localparam logic [2:0] S_WDATA_ACK = 3'd5;
    localparam logic [2:0] S_RDATA_ACK = 3'd7;

    i2c_slave_fsm dut (
        .i2c_scl      (i2c_scl),
        .reset_n      (reset_n),
        .i2c_sda      (i2c_sda),
        .valid_address(valid_address),
        .sda_out      (sda_out)
    );

    always #5 i2c_scl = ~i2c_scl;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive SDA well clear of the edge, then land just after the next rising SCL.
    task automatic tick(input logic b);
        i2c_sda = b;
        @(posedge i2c_scl);
        #1;
    endtask

    task automatic send_addr_rw(input logic [6:0] addr, input logic rw);
        tick(1'b0);
        for (int i = 6; i >= 0; i--) tick(addr[i]);
        tick(rw);
    endtask

    logic [2:0] st;
    logic [7:0] wbyte;

    initial begin
        reset_n = 1'b0;
        i2c_sda = 1'b1;
        #20;
        reset_n = 1'b1;
        st = dut.state_q;
        chk("reset_state", {5'd0, st}, {5'd0, S_IDLE});
        chk("reset_valid", {7'd0, valid_address}, 8'd0);
        chk("reset_sda", {7'd0, sda_out}, 8'd1);
        chk("reset_data", dut.data_q, 8'h00);
        tick(1'b1);
        tick(1'b1);
        st = dut.state_q;
        chk("idle_hold", {5'd0, st}, {5'd0, S_IDLE});

        // Matching write: address 1010100, rw=0, data 0xCC.
        send_addr_rw(7'b1010100, 1'b0);
        st = dut.state_q;
        chk("wr_ack_state", {5'd0, st}, {5'd0, S_ADDR_ACK});
        chk("wr_ack_valid", {7'd0, valid_address}, 8'd1);
        chk("wr_ack_sda", {7'd0, sda_out}, 8'd0);
        tick(1'b1);
        st = dut.state_q;
        chk("wr_wdata_state", {5'd0, st}, {5'd0, S_WDATA});
        chk("wr_wdata_sda", {7'd0, sda_out}, 8'd1);
        wbyte = 8'hCC;
        for (int i = 7; i >= 0; i--) tick(wbyte[i]);
        st = dut.state_q;
        chk("wr_dack_state", {5'd0, st}, {5'd0, S_WDATA_ACK});
        chk("wr_dack_sda", {7'd0, sda_out}, 8'd0);
        chk("wr_data_reg", dut.data_q, 8'hCC);
        tick(1'b1);
        st = dut.state_q;
        chk("wr_end_state", {5'd0, st}, {5'd0, S_IDLE});
        chk("wr_end_valid", {7'd0, valid_address}, 8'd0);
        chk("wr_end_sda", {7'd0, sda_out}, 8'd1);

        // Mismatched address 1010101 is ignored.
        send_addr_rw(7'b1010101, 1'b0);
        st = dut.state_q;
        chk("nm_state", {5'd0, st}, {5'd0, S_IDLE});
        chk("nm_valid", {7'd0, valid_address}, 8'd0);
        chk("nm_sda", {7'd0, sda_out}, 8'd1);
        tick(1'b1);
        st = dut.state_q;
        chk("nm_idle_hold", {5'd0, st}, {5'd0, S_IDLE});

        // Read back 0xCC: expected SDA 1,1,0,0,1,1,0,0.
        send_addr_rw(7'b1010100, 1'b1);
        chk("rd_ack_valid", {7'd0, valid_address}, 8'd1);
        chk("rd_ack_sda", {7'd0, sda_out}, 8'd0);
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1);
            chk($sformatf("rd_bit%0d", i), {7'd0, sda_out}, {7'd0, wbyte[i]});
        end
        tick(1'b1);
        st = dut.state_q;
        chk("rd_rack_state", {5'd0, st}, {5'd0, S_RDATA_ACK});
        chk("rd_rack_sda", {7'd0, sda_out}, 8'd1);
        chk("rd_rack_valid", {7'd0, valid_address}, 8'd1);
        tick(1'b0);
        st = dut.state_q;
        chk("rd_end_state", {5'd0, st}, {5'd0, S_IDLE});
        chk("rd_end_valid", {7'd0, valid_address}, 8'd0);
        tick(1'b1);

        // Reset asserted while WDATA is waiting for bit 3.
        send_addr_rw(7'b1010100, 1'b0);
        tick(1'b1);
        for (int i = 7; i >= 4; i--) tick(1'b1);
        st = dut.state_q;
        chk("mr_pre_state", {5'd0, st}, {5'd0, S_WDATA});
        #2;
        reset_n = 1'b0;
        #1;
        st = dut.state_q;
        chk("mr_state", {5'd0, st}, {5'd0, S_IDLE});
        chk("mr_valid", {7'd0, valid_address}, 8'd0);
        chk("mr_sda", {7'd0, sda_out}, 8'd1);
        chk("mr_data", dut.data_q, 8'h00);
        i2c_sda = 1'b1;
        #3;
        reset_n = 1'b1;
        tick(1'b1);
        st = dut.state_q;
        chk("mr_after_state", {5'd0, st}, {5'd0, S_IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
